// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the encoder and decoder.
// Opcodes, descriptor class codes, error codes and FSM states.
package rv_isa_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [6:0] F7_ALT = 7'h20;

  localparam logic [3:0] CL_R     = 4'd0;
  localparam logic [3:0] CL_I     = 4'd1;
  localparam logic [3:0] CL_L     = 4'd2;
  localparam logic [3:0] CL_S     = 4'd3;
  localparam logic [3:0] CL_B     = 4'd4;
  localparam logic [3:0] CL_J     = 4'd5;
  localparam logic [3:0] CL_JALR  = 4'd6;
  localparam logic [3:0] CL_LUI   = 4'd7;
  localparam logic [3:0] CL_AUIPC = 4'd8;
  localparam logic [3:0] CL_SYS   = 4'd9;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ILL   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_MIS   = 2'd3;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I field packer: descriptor -> {word, err}.
// ENCODER_RANGE_CHECK_EN enables immediate range/alignment checks.
module inst_field_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_alt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic [1:0]  o_err
);

  logic [6:0]  w_f7;
  logic        w_shift;
  logic        w_ill;
  logic        w_rng;
  logic        w_mis;
  logic [31:0] w_imm;

  assign w_imm   = i_imm;
  assign w_f7    = i_alt ? F7_ALT : 7'h00;
  assign w_shift = (i_funct3 == 3'd1) ||
                   (i_funct3 == 3'd5);

  // Pick the format for the class and flag illegal fields
  always_comb begin
    o_word = '0;
    w_ill  = 1'b0;
    case (i_class)
      CL_R: begin
        o_word = {w_f7, i_rs2, i_rs1,
                  i_funct3, i_rd, OP_R};
        w_ill  = i_alt &&
                 (i_funct3 != 3'd0) &&
                 (i_funct3 != 3'd5);
      end
      CL_I: begin
        if (w_shift) begin
          o_word = {w_f7, w_imm[4:0], i_rs1,
                    i_funct3, i_rd, OP_I};
        end else begin
          o_word = {w_imm[11:0], i_rs1,
                    i_funct3, i_rd, OP_I};
          w_ill  = i_alt;
        end
      end
      CL_L: begin
        o_word = {w_imm[11:0], i_rs1,
                  i_funct3, i_rd, OP_L};
      end
      CL_S: begin
        o_word = {w_imm[11:5], i_rs2, i_rs1,
                  i_funct3, w_imm[4:0], OP_S};
      end
      CL_B: begin
        o_word = {w_imm[12], w_imm[10:5],
                  i_rs2, i_rs1, i_funct3,
                  w_imm[4:1], w_imm[11], OP_B};
        w_ill  = (i_funct3 == 3'd2) ||
                 (i_funct3 == 3'd3);
      end
      CL_J: begin
        o_word = {w_imm[20], w_imm[10:1],
                  w_imm[11], w_imm[19:12],
                  i_rd, OP_J};
      end
      CL_JALR: begin
        o_word = {w_imm[11:0], i_rs1,
                  3'd0, i_rd, OP_JALR};
        w_ill  = (i_funct3 != 3'd0);
      end
      CL_LUI: begin
        o_word = {w_imm[31:12], i_rd, OP_LUI};
      end
      CL_AUIPC: begin
        o_word = {w_imm[31:12], i_rd, OP_AUIPC};
      end
      CL_SYS: begin
        o_word = w_imm[0] ? 32'h0010_0073
                          : 32'h0000_0073;
      end
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic w_s12;
  logic w_s13;
  logic w_s21;

  assign w_s12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_s13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_s21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  // Immediate must fit its field; B/J targets halfword aligned
  always_comb begin
    w_rng = 1'b0;
    w_mis = 1'b0;
    case (i_class)
      CL_I: w_rng = w_shift ? (|w_imm[31:5]) : !w_s12;
      CL_L, CL_S, CL_JALR: w_rng = !w_s12;
      CL_B: begin
        w_rng = !w_s13;
        w_mis = w_imm[0];
      end
      CL_J: begin
        w_rng = !w_s21;
        w_mis = w_imm[0];
      end
      CL_LUI, CL_AUIPC: w_rng = |w_imm[11:0];
      default: ;
    endcase
  end
`else
  assign w_rng = 1'b0;
  assign w_mis = 1'b0;
`endif

  assign o_err = w_ill ? ERR_ILL   :
                 w_rng ? ERR_RANGE :
                 w_mis ? ERR_MIS   : ERR_NONE;

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder with address tagging and word count.
// Optional ENCODER_RANGE_CHECK_EN checks immediates in the packer.
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_class,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_alt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [0:0]    r_state;
  logic          r_valid;
  logic [31:0]   r_inst;
  logic [31:0]   r_addr;
  logic [31:0]   r_next;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [1:0]    r_code;

  logic [31:0]   w_word;
  logic [1:0]    w_code;
  logic          w_acc;
  logic          w_load;
  logic          w_bad;
  logic [CW-1:0] w_cnt_inc;

  inst_field_pack u_pack (
    .i_class  (in_class),
    .i_funct3 (in_funct3),
    .i_alt    (in_alt),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_imm    (in_imm),
    .o_word   (w_word),
    .o_err    (w_code)
  );

  assign in_ready  = (r_state == ST_RUN) &&
                     (!r_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_bad     = (w_code != ERR_NONE);
  assign w_load    = w_acc && !w_bad;
  assign w_cnt_inc = r_count + CW'(1);

  // Output register, address/count tracking, FSM and error latch
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= ST_RUN;
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= BASE_ADDR;
      r_next  <= BASE_ADDR;
      r_count <= '0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_inst  <= w_word;
        r_addr  <= r_next;
        r_next  <= r_next + 32'd4;
        r_count <= w_cnt_inc;
        if (w_cnt_inc == DEPTH_C)
          r_state <= ST_FULL;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_acc && w_bad) begin
        r_err <= 1'b1;
        if (!r_err)
          r_code <= w_code;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_inst  = r_inst;
  assign out_addr  = r_addr;
  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign err       = r_err;
  assign err_code  = r_code;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder (DEPTH=4, BASE 0x1000).
// Directed literal checks, then random traffic vs. a reference model.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DEP  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        full;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3),
    .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .count(count), .full(full),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference encoder written from the RV32I format tables
  function automatic void enc(
    input  logic [3:0]  c,
    input  logic [2:0]  f3,
    input  logic        alt,
    input  logic [4:0]  rd, rs1, rs2,
    input  logic [31:0] imm,
    output logic [31:0] w,
    output logic [1:0]  e);
    logic [31:0] f7;
    longint v;
    bit sh;
    bit ill;
    int rng;
    v   = longint'($signed(imm));
    f7  = alt ? 32'h20 : 32'h0;
    sh  = (f3 == 1) || (f3 == 5);
    ill = 0;
    rng = 0;
    w   = 0;
    case (c)
      0: begin
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (rd << 7) | 32'h33;
        ill = alt && f3 != 0 && f3 != 5;
      end
      1: begin
        if (sh) begin
          w = (f7 << 25) | ((imm % 32) << 20);
          rng = (imm > 31) ? 2 : 0;
        end else begin
          w = (imm % 4096) << 20;
          ill = alt;
          rng = (v < -2048 || v > 2047) ? 2 : 0;
        end
        w = w | (rs1 << 15) | (f3 << 12)
          | (rd << 7) | 32'h13;
      end
      2, 3, 6: begin
        rng = (v < -2048 || v > 2047) ? 2 : 0;
        if (c == 3)
          w = (((imm >> 5) % 128) << 25)
            | (rs2 << 20) | (rs1 << 15)
            | (f3 << 12) | ((imm % 32) << 7)
            | 32'h23;
        else
          w = ((imm % 4096) << 20) | (rs1 << 15)
            | ((c == 2 ? f3 : 0) << 12) | (rd << 7)
            | (c == 2 ? 32'h03 : 32'h67);
        if (c == 6) ill = (f3 != 0);
      end
      4: begin
        w = (imm[12] << 31) | (imm[10:5] << 25)
          | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | (imm[4:1] << 8) | (imm[11] << 7)
          | 32'h63;
        ill = (f3 == 2 || f3 == 3);
        rng = (v < -4096 || v > 4095) ? 2
            : (imm[0] ? 3 : 0);
      end
      5: begin
        w = (imm[20] << 31) | (imm[10:1] << 21)
          | (imm[11] << 20) | (imm[19:12] << 12)
          | (rd << 7) | 32'h6F;
        rng = (v < -(64'sd1 << 20) ||
               v > (64'sd1 << 20) - 1) ? 2
            : (imm[0] ? 3 : 0);
      end
      7, 8: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7)
          | (c == 7 ? 32'h37 : 32'h17);
        rng = (imm % 4096 != 0) ? 2 : 0;
      end
      9: w = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      default: ill = 1;
    endcase
`ifndef ENCODER_RANGE_CHECK_EN
    rng = 0;
`endif
    e = ill ? 2'd1 : 2'(rng);
  endfunction

  // Model state
  bit          m_valid = 0;
  logic [31:0] m_inst = 0;
  logic [31:0] m_addr = BASE;
  int          m_idx = 0;
  int          m_count = 0;
  bit          m_err = 0;
  logic [1:0]  m_code = 0;

  function automatic bit m_rdy();
    return (m_count != DEP) &&
           (!m_valid || out_ready);
  endfunction

  // Advance the model on every clock edge
  always @(posedge clk) begin
    logic [31:0] w;
    logic [1:0]  e;
    bit acc;
    if (rst || clear) begin
      m_valid = 0; m_inst = 0; m_addr = BASE;
      m_idx = 0; m_count = 0; m_err = 0; m_code = 0;
    end else begin
      acc = in_valid && m_rdy();
      if (m_valid && out_ready) m_valid = 0;
      if (acc) begin
        enc(in_class, in_funct3, in_alt, in_rd,
            in_rs1, in_rs2, in_imm, w, e);
        if (e != 0) begin
          if (!m_err) m_code = e;
          m_err = 1;
        end else begin
          m_valid = 1;
          m_inst  = w;
          m_addr  = BASE + 32'(4 * m_idx);
          m_idx++;
          m_count++;
        end
      end
    end
  end

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_rdy()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("out_inst", out_inst, m_inst);
    chk("out_addr", out_addr, m_addr);
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == DEP));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic put(input logic [3:0] c,
                     input logic [2:0] f3,
                     input logic alt,
                     input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] imm);
    in_valid = 1; in_class = c; in_funct3 = f3;
    in_alt = alt; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm;
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    out_ready = 1;

    put(4'd12, 0, 0, 1, 1, 1, 0);
    step();
    chk("ill_err", 32'(err), 1);
    chk("ill_code", 32'(err_code), 1);
    chk("ill_count", 32'(count), 0);
    chk("ill_valid", 32'(out_valid), 0);

    put(0, 0, 0, 3, 1, 2, 0);
    step();
    chk("add", out_inst, 32'h002081B3);
    chk("add_addr", out_addr, BASE);
    put(0, 0, 1, 5, 6, 7, 0);
    step();
    chk("sub", out_inst, 32'h407302B3);
    chk("sub_addr", out_addr, BASE + 4);
    put(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    step();
    chk("addi", out_inst, 32'hFFF00093);
    put(7, 0, 0, 10, 0, 0, 32'h1234_5000);
    step();
    chk("lui", out_inst, 32'h12345537);
    chk("lui_full", 32'(full), 1);
    in_valid = 0;
    out_ready = 0;
    step();
    chk("full_rdy", 32'(in_ready), 0);
    chk("full_pend", 32'(out_valid), 1);
    clear = 1;
    step();
    clear = 0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_addr", out_addr, BASE);
    chk("clr_err", 32'(err), 0);
    chk("clr_code", 32'(err_code), 0);

    out_ready = 1;
    put(4, 0, 0, 0, 1, 2, 8);
    step();
    chk("beq", out_inst, 32'h00208463);
    out_ready = 0;
    put(5, 0, 0, 1, 0, 0, 2048);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_inst", out_inst, 32'h00208463);
      chk("bp_addr", out_addr, BASE);
      chk("bp_rdy", 32'(in_ready), 0);
    end
    out_ready = 1;
    step();
    chk("jal", out_inst, 32'h001000EF);
    chk("jal_addr", out_addr, BASE + 4);
    put(0, 0, 0, 3, 1, 2, 0);
    step();
    chk("b2b_addr", out_addr, BASE + 8);
    in_valid = 0;
    clear = 1;
    step();
    clear = 0;
    put(1, 0, 0, 1, 0, 0, 2048);
    step();
    in_valid = 0;
`ifdef ENCODER_RANGE_CHECK_EN
    chk("rng_code", 32'(err_code), 2);
    chk("rng_valid", 32'(out_valid), 0);
    chk("rng_count", 32'(count), 0);
`else
    chk("trunc", out_inst, 32'h80000093);
    chk("trunc_count", 32'(count), 1);
`endif
    clear = 1;
    step();
    clear = 0;

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] imm;
      logic [3:0]  c;
      logic [2:0]  f3;
      c = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                              : 4'($urandom_range(0, 9));
      f3 = 3'($urandom);
      if (c == 6 && $urandom % 2 == 0) f3 = 0;
      case ($urandom % 4)
        0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        1: imm = $urandom;
        2: imm = $urandom & 32'h0000_001F;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      if ($urandom % 3 == 0) imm = imm & ~32'h1;
      put(c, f3, ($urandom % 6 == 0), 5'($urandom),
          5'($urandom), 5'($urandom), imm);
      in_valid = ($urandom % 10 < 8);
      out_ready = ($urandom % 10 < 7);
      clear = (m_count == DEP) ? ($urandom % 4 == 0)
                               : ($urandom % 150 == 0);
      step();
    end
    in_valid = 0;
    clear = 0;
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
